// File: rtl/uart_avmm_responder_pkg.sv
// Register map, status bit positions and bus-access state for the UART-style
// Avalon-MM responder.
package uart_avmm_pkg;

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    localparam int TX_OK_BIT = 6;
    localparam int RX_OK_BIT = 7;
    localparam int OVF_BIT   = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } acc_state_t;

    function automatic logic [31:0] status_word(input logic rx_ok,
                                                input logic tx_ok,
                                                input logic ovf);
        logic [31:0] w;
        w            = '0;
        w[RX_OK_BIT] = rx_ok;
        w[TX_OK_BIT] = tx_ok;
        w[OVF_BIT]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/uart_avmm_responder_byte_fifo.sv
// Byte FIFO with first-word-fall-through head; pushes when full and pops when
// empty are ignored, so a simultaneous push/pop on empty keeps the new byte.
module byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    // Head reads as zero when empty so nothing undefined leaks onto the outputs.
    assign rdata   = empty ? 8'h00 : mem[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= wdata;
    end

endmodule

// File: rtl/uart_avmm_responder.sv
// Avalon-MM slave mimicking a polled RS-232 UART: RX reads drain a byte FIFO
// fed by a stream, TX writes fill a byte FIFO drained by a stream.
module uart_avmm_responder
    import uart_avmm_pkg::*;
#(
    parameter int RX_DEPTH = 64,
    parameter int TX_DEPTH = 64
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready
);
    acc_state_t  state_reg, state_next;
    logic [31:0] readdata_reg, readdata_next;
    logic        ovf_reg, ovf_next;
    logic        rx_pop, tx_push;
    logic [7:0]  rx_head;
    logic        rx_full, rx_empty, tx_full, tx_empty;
    logic        unused_wdata;

    assign unused_wdata = &{1'b0, avs_writedata[31:8]};

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (avm_clk),
        .rst   (avm_rst),
        .push  (i_rx_valid & ~rx_full),
        .pop   (rx_pop),
        .wdata (i_rx_data),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (avm_clk),
        .rst   (avm_rst),
        .push  (tx_push),
        .pop   (~tx_empty & i_tx_ready),
        .wdata (avs_writedata[7:0]),
        .rdata (o_tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign o_rx_ready      = ~rx_full;
    assign o_tx_valid      = ~tx_empty;
    assign avs_readdata    = readdata_reg;
    assign avs_waitrequest = (avs_read | avs_write) & (state_reg == ST_IDLE);

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_reg    <= ST_IDLE;
            readdata_reg <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            readdata_reg <= readdata_next;
            ovf_reg      <= ovf_next;
        end
    end

    // All side effects land on the IDLE edge; status uses pre-edge occupancy.
    always_comb begin
        state_next    = state_reg;
        readdata_next = readdata_reg;
        ovf_next      = ovf_reg;
        rx_pop        = 1'b0;
        tx_push       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (avs_read | avs_write) begin
                    state_next = ST_ACK;
                    if (avs_read) begin
                        readdata_next = '0;
                        case (avs_address)
                            RX_BASE: begin
                                readdata_next = {24'b0, rx_head};
                                rx_pop        = ~rx_empty;
                            end
                            STATUS_BASE: begin
                                readdata_next = status_word(~rx_empty, ~tx_full, ovf_reg);
                                ovf_next      = 1'b0;
                            end
                            default: readdata_next = '0;
                        endcase
                    end else if (avs_address == TX_BASE) begin
                        if (tx_full) ovf_next = 1'b1;
                        else         tx_push  = 1'b1;
                    end
                end
            end
            ST_ACK: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_avmm_responder.sv
// Directed and randomized checks of uart_avmm_responder against a queue-based
// model of the register map and both byte streams.
module tb_uart_avmm_responder;
    localparam int RXD = 64;
    localparam int TXD = 64;

    logic        avm_clk = 1'b0;
    logic        avm_rst = 1'b1;
    logic [4:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_waitrequest;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;

    always #5 avm_clk = ~avm_clk;

    uart_avmm_responder #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_waitrequest (avs_waitrequest),
        .i_rx_data       (i_rx_data),
        .i_rx_valid      (i_rx_valid),
        .o_rx_ready      (o_rx_ready),
        .o_tx_data       (o_tx_data),
        .o_tx_valid      (o_tx_valid),
        .i_tx_ready      (i_tx_ready)
    );

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    bit         ovf_m = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    bit         rx_rand = 1'b0;
    bit         tx_rand = 1'b0;
    int         rx_pct = 0;
    int         rx_limit = 0;
    int         rx_seq = 0;
    logic [7:0] rx_xor = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check streams, apply the model's effects of the coming edge.
    task automatic cycle(input bit cap, input bit rd, input bit wr, input logic [4:0] a,
                         input logic [31:0] wd, output logic [31:0] e);
        int rxn;
        int txn;
        bit rx_acc;
        if (rx_rand) begin
            i_rx_valid = (rx_seq < rx_limit) && (int'($urandom_range(99)) < rx_pct);
            i_rx_data  = 8'(rx_seq) ^ rx_xor;
        end
        if (tx_rand) i_tx_ready = 1'($urandom_range(1));
        #1;
        rxn = rx_q.size();
        txn = tx_q.size();
        chk("rx_ready", 32'(o_rx_ready), 32'(rxn < RXD));
        chk("tx_valid", 32'(o_tx_valid), 32'(txn > 0));
        chk("tx_data", 32'(o_tx_data), (txn > 0) ? 32'(tx_q[0]) : 32'd0);
        e = '0;
        if (cap && rd) begin
            if (a == 5'd0) begin
                if (rxn > 0) e = 32'(rx_q.pop_front());
            end else if (a == 5'd8) begin
                e[8]  = ovf_m;
                e[7]  = (rxn > 0);
                e[6]  = (txn < TXD);
                ovf_m = 1'b0;
            end
        end else if (cap && wr && a == 5'd4) begin
            if (txn < TXD) tx_q.push_back(wd[7:0]);
            else           ovf_m = 1'b1;
        end
        rx_acc = i_rx_valid && (rxn < RXD);
        if (rx_acc) rx_q.push_back(i_rx_data);
        if (i_tx_ready && txn > 0) void'(tx_q.pop_front());
        @(posedge avm_clk);
        @(negedge avm_clk);
        if (rx_acc) rx_seq++;
    endtask

    task automatic idle(input int n);
        logic [31:0] d;
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, d);
    endtask

    task automatic bus(input bit rd, input bit wr, input logic [4:0] a,
                       input logic [31:0] wd, output logic [31:0] rv);
        logic [31:0] e;
        logic [31:0] d;
        avs_read      = rd;
        avs_write     = wr;
        avs_address   = a;
        avs_writedata = wd;
        #1;
        chk("wait_req", 32'(avs_waitrequest), 32'd1);
        cycle(1'b1, rd, wr, a, wd, e);
        chk("wait_ack", 32'(avs_waitrequest), 32'd0);
        if (rd) chk("readdata", avs_readdata, e);
        rv = e;
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, d);
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rv;
        int got;
        int iter;
        int kind;
        logic [4:0] a;

        // Reset state
        @(negedge avm_clk);
        chk("rst_readdata", avs_readdata, 32'd0);
        chk("rst_wait", 32'(avs_waitrequest), 32'd0);
        chk("rst_rx_ready", 32'(o_rx_ready), 32'd1);
        chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_tx_data", 32'(o_tx_data), 32'd0);
        @(negedge avm_clk);
        avm_rst = 1'b0;
        idle(1);

        bus(1'b1, 1'b0, 5'd8, 32'd0, rv);
        chk("status_after_rst", avs_readdata, 32'h40);

        // Single RX byte through the stream
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h41;
        idle(1);
        i_rx_valid = 1'b0;
        bus(1'b1, 1'b0, 5'd8, 32'd0, rv);
        chk("status_rx_ok", 32'(rv[7]), 32'd1);
        bus(1'b1, 1'b0, 5'd0, 32'd0, rv);
        chk("rx_byte_41", rv, 32'h41);
        bus(1'b1, 1'b0, 5'd8, 32'd0, rv);
        chk("status_rx_empty", 32'(rv[7]), 32'd0);

        // Empty RX read, then unmapped accesses
        bus(1'b1, 1'b0, 5'd0, 32'd0, rv);
        chk("rx_empty_read", rv, 32'd0);
        bus(1'b1, 1'b0, 5'd8, 32'd0, rv);
        bus(1'b0, 1'b1, 5'd16, 32'h5A, rv);
        bus(1'b1, 1'b0, 5'd12, 32'd0, rv);

        // TX byte held by a stalled sink
        bus(1'b0, 1'b1, 5'd4, 32'h1AB, rv);
        chk("tx_head_ab", 32'(o_tx_data), 32'hAB);
        i_tx_ready = 1'b1;
        idle(1);
        i_tx_ready = 1'b0;
        chk("tx_valid_drop", 32'(o_tx_valid), 32'd0);

        // Fill TX past capacity
        for (int i = 0; i < 64; i++) bus(1'b0, 1'b1, 5'd4, $urandom, rv);
        bus(1'b1, 1'b0, 5'd8, 32'd0, rv);
        chk("tx_full_txok", 32'(rv[6]), 32'd0);
        chk("tx_full_noovf", 32'(rv[8]), 32'd0);
        bus(1'b0, 1'b1, 5'd4, 32'hEE, rv);
        bus(1'b1, 1'b0, 5'd8, 32'd0, rv);
        chk("ovf_status", rv, 32'h100);
        bus(1'b1, 1'b0, 5'd8, 32'd0, rv);
        chk("ovf_cleared", 32'(rv[8]), 32'd0);
        tx_rand = 1'b1;
        iter = 0;
        while (tx_q.size() > 0 && iter < 1000) begin
            idle(1);
            iter++;
        end
        chk("tx_drained", 32'(tx_q.size()), 32'd0);
        tx_rand    = 1'b0;
        i_tx_ready = 1'b0;

        // RX fill to full, then poll/read with pushes pending at full
        rx_rand  = 1'b1;
        rx_xor   = 8'h00;
        rx_seq   = 0;
        rx_limit = 100;
        rx_pct   = 100;
        idle(70);
        chk("rx_full_ready", 32'(o_rx_ready), 32'd0);
        rx_pct = 60;
        got  = 0;
        iter = 0;
        while (got < 100 && iter < 3000) begin
            bus(1'b1, 1'b0, 5'd8, 32'd0, rv);
            if (rv[7]) begin
                bus(1'b1, 1'b0, 5'd0, 32'd0, rv);
                chk("rx_order", 32'(rv[7:0]), 32'(8'(got)));
                got++;
            end
            iter++;
        end
        chk("rx_all_read", 32'(got), 32'd100);

        // Random mixed traffic
        tx_rand  = 1'b1;
        rx_pct   = 40;
        rx_limit = 32'h7fffffff;
        rx_xor   = 8'($urandom);
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(3))
                0:       a = 5'd0;
                1:       a = 5'd4;
                2:       a = 5'd8;
                default: a = 5'($urandom);
            endcase
            kind = int'($urandom_range(2));
            bus(kind != 1, kind != 0, a, $urandom, rv);
            idle(int'($urandom_range(2)));
        end

        // Reset in the middle of an RX read
        rx_rand    = 1'b0;
        tx_rand    = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h77;
        i_tx_ready = 1'b0;
        idle(1);
        i_rx_valid  = 1'b0;
        avs_read    = 1'b1;
        avs_address = 5'd0;
        @(posedge avm_clk);
        @(negedge avm_clk);
        avm_rst  = 1'b1;
        avs_read = 1'b0;
        #1;
        rx_q.delete();
        tx_q.delete();
        ovf_m = 1'b0;
        chk("midrst_readdata", avs_readdata, 32'd0);
        chk("midrst_rx_ready", 32'(o_rx_ready), 32'd1);
        chk("midrst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("midrst_wait", 32'(avs_waitrequest), 32'd0);
        @(negedge avm_clk);
        avm_rst = 1'b0;
        idle(1);
        bus(1'b1, 1'b0, 5'd8, 32'd0, rv);
        chk("status_after_midrst", avs_readdata, 32'h40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
